// File: rtl/jtcop_mcu_pkg.sv
// Shared definitions for the 68000 <-> i8751 mailbox bridge.
// Holds the MCU port-2 bit positions, the INT1 handshake state encoding
// and the default acknowledge timeout.
package jtcop_mcu_pkg;

  // Bit positions inside mcu_p2o
  localparam int P2_ACK  = 3;
  localparam int P2_RDHI = 4;
  localparam int P2_RDLO = 5;
  localparam int P2_WRLO = 6;
  localparam int P2_WRHI = 7;

  localparam logic [15:0] TOUT_DEF = 16'd4096;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_e;

endpackage

// File: rtl/jtcop_mcu_irq.sv
// INT1 handshake towards the protection MCU.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : one-cycle interrupt request (main CPU posted a command)
//   ack          : MCU acknowledge, active-high level
//   int1n        : registered INT1 to the MCU, active-low
//   tout_pulse   : one-cycle pulse on the edge that releases INT1 by timeout
module jtcop_mcu_irq
  import jtcop_mcu_pkg::*;
#(
  parameter logic [15:0] TOUT = TOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic int1n,
  output logic tout_pulse
);

  irq_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        int1n_q, int1n_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    tout_pulse = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (req || pend_q) begin
          state_d = IRQ_REQ;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      IRQ_REQ: begin
        if (ack) begin
          // Ack has priority; a request landing in the same cycle is
          // remembered and re-asserts INT1 one cycle later.
          state_d = IRQ_IDLE;
          pend_d  = req;
        end else if (req) begin
          cnt_d = '0;
        end else if (cnt_q == TOUT - 16'd1) begin
          state_d    = IRQ_IDLE;
          tout_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
    int1n_d = (state_d == IRQ_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      int1n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      int1n_q <= int1n_d;
    end
  end

  assign int1n = int1n_q;

endmodule

// File: rtl/jtcop_mcu_bridge.sv
// Command/response mailbox between the main 68000 and the i8751 MCU.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   main_cs/rnw/dsn/dout       : main CPU access to the MCU window
//   main_din                   : response word returned to the main CPU
//   mcu_p0o / mcu_p2o          : MCU port outputs (data, strobes, INT ack)
//   mcu_p0i                    : command byte presented to the MCU
//   mcu_int1n                  : MCU INT1, active-low
//   cmd_full, rsp_valid        : mailbox status flags
//   ack_tout                   : sticky, INT1 was released by timeout
module jtcop_mcu_bridge
  import jtcop_mcu_pkg::*;
#(
  parameter logic [15:0] TOUT = TOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        main_cs,
  input  logic        main_rnw,
  input  logic [1:0]  main_dsn,
  input  logic [15:0] main_dout,
  output logic [15:0] main_din,
  input  logic [7:0]  mcu_p0o,
  input  logic [7:0]  mcu_p2o,
  output logic [7:0]  mcu_p0i,
  output logic        mcu_int1n,
  output logic        cmd_full,
  output logic        rsp_valid,
  output logic        ack_tout
);

  logic        cs_q;
  logic [3:0]  p2_q;        // previous mcu_p2o[7:4]
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] rsp_q, rsp_d;
  logic [15:0] din_q, din_d;
  logic [7:0]  p0i_q, p0i_d;
  logic        full_q, full_d;
  logic        valid_q, valid_d;
  logic        tout_q, tout_d;

  logic        main_wr, main_rd;
  logic [3:0]  p2_fall;
  logic        rd_hi, rd_lo, wr_hi, wr_lo;
  logic        tout_pulse;
  logic        unused_p2;

  assign main_wr = main_cs & ~cs_q & ~main_rnw;
  assign main_rd = main_cs & ~cs_q & main_rnw;
  assign p2_fall = p2_q & ~mcu_p2o[7:4];
  assign rd_hi   = p2_fall[P2_RDHI-4];
  assign rd_lo   = p2_fall[P2_RDLO-4];
  assign wr_lo   = p2_fall[P2_WRLO-4];
  assign wr_hi   = p2_fall[P2_WRHI-4];
  assign unused_p2 = ^mcu_p2o[2:0];

  // All reads use the pre-edge register values, so a collision hands the
  // reader the old data while the flag update gives priority to the writer.
  always_comb begin
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    din_d   = din_q;
    p0i_d   = p0i_q;
    full_d  = full_q;
    valid_d = valid_q;
    tout_d  = tout_q;

    if (main_wr) begin
      if (!main_dsn[1]) cmd_d[15:8] = main_dout[15:8];
      if (!main_dsn[0]) cmd_d[7:0]  = main_dout[7:0];
    end
    if (rd_lo)      p0i_d = cmd_q[7:0];
    else if (rd_hi) p0i_d = cmd_q[15:8];
    if (rd_lo)   full_d = 1'b0;
    if (main_wr) full_d = 1'b1;

    if (wr_hi) rsp_d[15:8] = mcu_p0o;
    if (wr_lo) rsp_d[7:0]  = mcu_p0o;
    if (main_rd) begin
      din_d   = rsp_q;
      valid_d = 1'b0;
    end
    if (wr_lo) valid_d = 1'b1;

    if (tout_pulse) tout_d = 1'b1;
    if (main_wr)    tout_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q    <= 1'b0;
      p2_q    <= 4'h0;    // no falling edge until a strobe has been seen high
      cmd_q   <= '0;
      rsp_q   <= '0;
      din_q   <= '0;
      p0i_q   <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      cs_q    <= main_cs;
      p2_q    <= mcu_p2o[7:4];
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
      din_q   <= din_d;
      p0i_q   <= p0i_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  jtcop_mcu_irq #(
    .TOUT (TOUT)
  ) u_irq (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (main_wr),
    .ack        (~mcu_p2o[P2_ACK]),
    .int1n      (mcu_int1n),
    .tout_pulse (tout_pulse)
  );

  assign main_din  = din_q;
  assign mcu_p0i   = p0i_q;
  assign cmd_full  = full_q;
  assign rsp_valid = valid_q;
  assign ack_tout  = tout_q;

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
module tb_jtcop_mcu_bridge;

  logic        clk;
  logic        rst_n;
  logic        main_cs;
  logic        main_rnw;
  logic [1:0]  main_dsn;
  logic [15:0] main_dout;
  logic [15:0] main_din;
  logic [7:0]  mcu_p0o;
  logic [7:0]  mcu_p2o;
  logic [7:0]  mcu_p0i;
  logic        mcu_int1n;
  logic        cmd_full;
  logic        rsp_valid;
  logic        ack_tout;

  int checks;
  int failures;

  jtcop_mcu_bridge #(
    .TOUT (16'd8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .main_cs   (main_cs),
    .main_rnw  (main_rnw),
    .main_dsn  (main_dsn),
    .main_dout (main_dout),
    .main_din  (main_din),
    .mcu_p0o   (mcu_p0o),
    .mcu_p2o   (mcu_p2o),
    .mcu_p0i   (mcu_p0i),
    .mcu_int1n (mcu_int1n),
    .cmd_full  (cmd_full),
    .rsp_valid (rsp_valid),
    .ack_tout  (ack_tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic main_wr(input logic [15:0] d, input logic [1:0] dsn);
    main_cs = 1'b1; main_rnw = 1'b0; main_dsn = dsn; main_dout = d;
    tick;
    main_cs = 1'b0; main_rnw = 1'b1; main_dsn = 2'b11;
  endtask

  task automatic main_rd;
    main_cs = 1'b1; main_rnw = 1'b1;
    tick;
    main_cs = 1'b0;
  endtask

  task automatic p2(input int b, input logic [7:0] d);
    mcu_p0o = d;
    mcu_p2o = 8'hFF;
    mcu_p2o[b] = 1'b0;
    tick;
    mcu_p2o = 8'hFF;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; main_cs = 1'b0; main_rnw = 1'b1; main_dsn = 2'b11;
    main_dout = 16'h0; mcu_p0o = 8'h00; mcu_p2o = 8'hFF;
    repeat (3) tick;
    chk("rst_main_din", main_din, 16'h0000);
    chk("rst_p0i", {8'h0, mcu_p0i}, 16'h0000);
    chk("rst_int1n", {15'h0, mcu_int1n}, 16'h0001);
    chk("rst_cmd_full", {15'h0, cmd_full}, 16'h0000);
    chk("rst_rsp_valid", {15'h0, rsp_valid}, 16'h0000);
    chk("rst_ack_tout", {15'h0, ack_tout}, 16'h0000);
    rst_n = 1'b1;
    tick;

    // Main write, MCU reads both bytes, then acks
    main_wr(16'hA55A, 2'b00);
    chk("wr_int1n", {15'h0, mcu_int1n}, 16'h0000);
    chk("wr_cmd_full", {15'h0, cmd_full}, 16'h0001);
    tick;
    p2(4, 8'h00);
    chk("rdhi_p0i", {8'h0, mcu_p0i}, 16'h00A5);
    chk("rdhi_cmd_full", {15'h0, cmd_full}, 16'h0001);
    p2(5, 8'h00);
    chk("rdlo_p0i", {8'h0, mcu_p0i}, 16'h005A);
    chk("rdlo_cmd_full", {15'h0, cmd_full}, 16'h0000);
    p2(3, 8'h00);
    chk("ack_int1n", {15'h0, mcu_int1n}, 16'h0001);
    chk("ack_tout_clear", {15'h0, ack_tout}, 16'h0000);
    tick;
    chk("p0i_hold", {8'h0, mcu_p0i}, 16'h005A);

    // Byte lane write
    main_wr(16'h1234, 2'b00);
    tick;
    main_wr(16'hFFFF, 2'b10);
    tick;
    p2(4, 8'h00);
    chk("lane_hi", {8'h0, mcu_p0i}, 16'h0012);
    p2(5, 8'h00);
    chk("lane_lo", {8'h0, mcu_p0i}, 16'h00FF);
    p2(3, 8'h00);
    chk("lane_ack_int1n", {15'h0, mcu_int1n}, 16'h0001);

    // MCU response
    p2(7, 8'hC3);
    chk("rsp_hi_valid", {15'h0, rsp_valid}, 16'h0000);
    p2(6, 8'h3C);
    chk("rsp_lo_valid", {15'h0, rsp_valid}, 16'h0001);
    tick;
    main_rd;
    chk("rsp_main_din", main_din, 16'hC33C);
    chk("rsp_read_valid", {15'h0, rsp_valid}, 16'h0000);

    // Timeout: INT1 low for exactly 8 cycles
    tick;
    main_wr(16'h0001, 2'b00);
    chk("tout_int1n_0", {15'h0, mcu_int1n}, 16'h0000);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("tout_int1n_low", {15'h0, mcu_int1n}, 16'h0000);
    end
    chk("tout_flag_pre", {15'h0, ack_tout}, 16'h0000);
    tick;
    chk("tout_int1n_rel", {15'h0, mcu_int1n}, 16'h0001);
    chk("tout_flag_set", {15'h0, ack_tout}, 16'h0001);
    tick;
    main_wr(16'hBEEF, 2'b00);
    chk("tout_flag_clr", {15'h0, ack_tout}, 16'h0000);
    chk("tout_wr_int1n", {15'h0, mcu_int1n}, 16'h0000);
    p2(3, 8'h00);
    chk("tout_ack_int1n", {15'h0, mcu_int1n}, 16'h0001);

    // Main write colliding with MCU low-byte read
    tick;
    main_cs = 1'b1; main_rnw = 1'b0; main_dsn = 2'b00; main_dout = 16'h7788;
    mcu_p2o = 8'hFF; mcu_p2o[5] = 1'b0;
    tick;
    main_cs = 1'b0; main_rnw = 1'b1; main_dsn = 2'b11; mcu_p2o = 8'hFF;
    chk("col_p0i_old", {8'h0, mcu_p0i}, 16'h00EF);
    chk("col_cmd_full", {15'h0, cmd_full}, 16'h0001);
    tick;
    p2(5, 8'h00);
    chk("col_p0i_new", {8'h0, mcu_p0i}, 16'h0088);
    p2(3, 8'h00);

    // Request and ack in the same cycle
    tick;
    main_wr(16'h4242, 2'b00);
    tick;
    main_cs = 1'b1; main_rnw = 1'b0; main_dsn = 2'b00; main_dout = 16'h4243;
    mcu_p2o = 8'hFF; mcu_p2o[3] = 1'b0;
    tick;
    main_cs = 1'b0; main_rnw = 1'b1; main_dsn = 2'b11; mcu_p2o = 8'hFF;
    chk("reqack_int1n_hi", {15'h0, mcu_int1n}, 16'h0001);
    tick;
    chk("reqack_int1n_lo", {15'h0, mcu_int1n}, 16'h0000);
    p2(3, 8'h00);
    chk("reqack_release", {15'h0, mcu_int1n}, 16'h0001);

    // Main read colliding with MCU low-byte write
    p2(7, 8'h55);
    chk("rcol_valid_pre", {15'h0, rsp_valid}, 16'h0000);
    main_cs = 1'b1; main_rnw = 1'b1;
    mcu_p0o = 8'hAA; mcu_p2o = 8'hFF; mcu_p2o[6] = 1'b0;
    tick;
    main_cs = 1'b0; mcu_p2o = 8'hFF;
    chk("rcol_main_din", main_din, 16'h553C);
    chk("rcol_valid", {15'h0, rsp_valid}, 16'h0001);
    tick;
    main_rd;
    chk("rcol_din_new", main_din, 16'h55AA);

    // Reset in the middle of an interrupt request
    tick;
    p2(6, 8'h01);
    tick;
    main_wr(16'h1111, 2'b00);
    chk("pre_rst_int1n", {15'h0, mcu_int1n}, 16'h0000);
    chk("pre_rst_full", {15'h0, cmd_full}, 16'h0001);
    chk("pre_rst_valid", {15'h0, rsp_valid}, 16'h0001);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_main_din", main_din, 16'h0000);
    chk("mid_rst_p0i", {8'h0, mcu_p0i}, 16'h0000);
    chk("mid_rst_int1n", {15'h0, mcu_int1n}, 16'h0001);
    chk("mid_rst_cmd_full", {15'h0, cmd_full}, 16'h0000);
    chk("mid_rst_rsp_valid", {15'h0, rsp_valid}, 16'h0000);
    chk("mid_rst_ack_tout", {15'h0, ack_tout}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtcop_mcu_bridge.md
# jtcop_mcu_bridge

Mailbox between the 68000 main CPU and the i8751 protection MCU in the JTCOP core. It sits at the boundary between the main CPU's MCU window (`sec[0]`) and the MCU's P0/P2 ports. The main CPU posts a 16-bit command and raises MCU INT1. The MCU then reads the command a byte at a time and writes a 16-bit response that the main CPU collects. The block tracks full/valid status, the interrupt handshake and an acknowledge timeout.

## Interface
Parameters:
- `TOUT`, default 16'd4096: clk cycles INT1 may stay asserted without MCU acknowledge before forced release.

Ports:
- `clk` in 1: single clock (clk24 domain); all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `main_cs` in 1: main CPU access strobe to the MCU window; level, one access per rising edge.
- `main_rnw` in 1: 1 = read, 0 = write; sampled on the `main_cs` rising edge.
- `main_dsn` in 2: byte lane enables, active-low; [1] = upper, [0] = lower.
- `main_dout` in 16: main CPU write data.
- `main_din` out 16: response word returned to the main CPU.
- `mcu_p0o` in 8: MCU port 0 output (write data).
- `mcu_p2o` in 8: MCU port 2 output. [3] = INT ack (low), [4] = rd hi, [5] = rd lo, [6] = wr lo, [7] = wr hi; [7:4] active-low.
- `mcu_p0i` out 8: MCU port 0 input (read data).
- `mcu_int1n` out 1: MCU INT1, active-low.
- `cmd_full` out 1: command posted, low byte not yet read by MCU.
- `rsp_valid` out 1: response complete, not yet read by main CPU.
- `ack_tout` out 1: sticky, set when INT1 was released by timeout.

## Operation
- **Reset values:** `main_din`=0, `mcu_p0i`=0, `mcu_int1n`=1, `cmd_full`=0, `rsp_valid`=0, `ack_tout`=0. The FSM is in IDLE and the counter is 0.
- **Edge detection:** one previous-value register per strobe. `main_cs` acts on its rising edge; `mcu_p2o[7:4]` act on falling edges. A strobe held for many cycles acts once.
- **Main write** (`main_cs`↑, `main_rnw`=0): each lane with `main_dsn` bit low loads `cmd` from `main_dout`. Then `cmd_full`←1, `ack_tout`←0, and an interrupt request is raised.
- **Main read** (`main_cs`↑, `main_rnw`=1): `main_din`←`rsp`, `rsp_valid`←0.
- **MCU reads:**
  - p2[4]↓: `mcu_p0i`←`cmd[15:8]`.
  - p2[5]↓: `mcu_p0i`←`cmd[7:0]` and `cmd_full`←0.
  - Both in one cycle: lower byte wins.
  - `mcu_p0i` holds between strobes.
- **MCU writes:**
  - p2[7]↓: `rsp[15:8]`←`mcu_p0o`.
  - p2[6]↓: `rsp[7:0]`←`mcu_p0o` and `rsp_valid`←1.
  - Both in one cycle: both bytes are written and `rsp_valid`←1.
- **IRQ FSM:**
  - IDLE (`int1n`=1): on request go to REQ and clear the counter.
  - REQ (`int1n`=0): counter increments each cycle.
    - `mcu_p2o[3]`=0 → IDLE.
    - Counter reaches `TOUT`-1 → IDLE and `ack_tout`←1.
  - A request arriving while in REQ restarts the counter.
  - Request and ack in the same cycle: ack wins, the request is kept pending, and REQ is entered on the next cycle.
- **Collisions:**
  - Main write coinciding with an MCU low-byte read: the MCU gets the old `cmd` value and `cmd_full` ends at 1 (write wins).
  - Main read coinciding with an MCU low-byte write: `main_din` gets the old `rsp` and `rsp_valid` ends at 1.
- **Mid-operation reset:** `rst_n` low at any time returns every output to its reset value asynchronously. Pending requests are dropped.

## Timing
- All outputs are registered.
- Strobe edge at cycle N (input sampled) → register/flag updated and visible at N+1.
- Main write at N → `mcu_int1n` low at N+1.
- Ack low sampled at N → `mcu_int1n` high at N+1.
- Timeout: `mcu_int1n` stays low for exactly `TOUT` cycles, then goes high and `ack_tout` sets in the same cycle.
- No back-pressure; the main CPU polls `cmd_full`/`rsp_valid` via the status path.

## Structure
- **Package `jtcop_mcu_pkg`:**
  - P2 bit-index constants: ACK=3, RDHI=4, RDLO=5, WRLO=6, WRHI=7.
  - IRQ state enum {IDLE, REQ}.
  - Default `TOUT`.
- **Sub-module `jtcop_mcu_irq`:** IRQ FSM, pending flag and timeout counter. Inputs are request/ack/clk/rst_n; outputs are `int1n` and `tout_pulse`.
- The top holds the edge detectors, the `cmd`/`rsp` registers and the flags.

## Test plan
- **Main write, MCU reads back:** write 16'hA55A with dsn=00, then p2[4]↓ then p2[5]↓. Expect `mcu_int1n`=0 at N+1, p0i=8'hA5 then 8'h5A, and `cmd_full` 1→0 after the low read.
- **Byte lane write:** cmd=16'h1234, then write 16'hFFFF with dsn=10. Expect cmd=16'h12FF.
- **MCU response:** p0o=8'hC3 with p2[7]↓, then p0o=8'h3C with p2[6]↓. Expect `rsp_valid`=1. A main read then gives `main_din`=16'hC33C and `rsp_valid`=0.
- **Ack vs timeout:** with `TOUT`=8, ack at cycle 3 releases INT1 and `ack_tout`=0. With no ack, INT1 is low for exactly 8 cycles and `ack_tout`=1; the next main write clears it.
- **Collisions:** main write and p2[5]↓ in the same cycle: p0i gets the old low byte and `cmd_full`=1. Request and ack in the same cycle: INT1 high for one cycle, then low.
- **Reset mid-REQ:** assert `rst_n`=0 while `mcu_int1n`=0 and both flags set. All outputs reach reset values without waiting for a clk edge.
